// File: rtl/comar_share_gen.sv
// comar_share_gen: Boolean share and fresh-randomness generator for a first-order masked-AND gadget.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready, a, b : unmasked operand pair handshake (in_ready combinational)
//   seed_valid, seed        : reseed request; a zero seed is replaced by a fixed constant
//   a0, a1, b0, b1          : registered Boolean shares of a and b
//   r0, r1, r_0..r_3        : registered fresh randomness bytes
//   out_valid               : registered pulse, one per accepted pair
//   res_valid               : out_valid delayed LATENCY cycles (gadget result valid)
module comar_share_gen #(
    parameter int          WIDTH   = 8,
    parameter logic [63:0] SEED    = 64'h0000_0000_0000_0001,
    parameter int          LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             seed_valid,
    input  logic [63:0]      seed,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r_0,
    output logic [WIDTH-1:0] r_1,
    output logic [WIDTH-1:0] r_2,
    output logic [WIDTH-1:0] r_3,
    output logic             out_valid,
    output logic             res_valid
);
    localparam logic [63:0] ZERO_SUB = 64'h9E37_79B9_7F4A_7C15;

    typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // xorshift has an all-zero fixed point, so a zero seed is never loaded
    function automatic logic [63:0] fix(input logic [63:0] v);
        return (v == 64'd0) ? ZERO_SUB : v;
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [63:0]        s_q, s_d;
    logic [WIDTH-1:0]   a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic [WIDTH-1:0]   r0_q, r0_d, r1_q, r1_d;
    logic [WIDTH-1:0]   rr0_q, rr0_d, rr1_q, rr1_d, rr2_q, rr2_d, rr3_q, rr3_d;
    logic               out_valid_q, out_valid_d;
    logic [LATENCY-1:0] pipe_q, pipe_d;
    logic               run, acc;

    // rst gates in_ready so nothing is taken while the block is being reset
    assign run      = (state_q == RUN);
    assign in_ready = run && !seed_valid && !rst;
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WARMUP;
            cnt_q       <= 2'd0;
            s_q         <= fix(SEED);
            a0_q        <= '0;
            a1_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            rr0_q       <= '0;
            rr1_q       <= '0;
            rr2_q       <= '0;
            rr3_q       <= '0;
            out_valid_q <= 1'b0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            rr0_q       <= rr0_d;
            rr1_q       <= rr1_d;
            rr2_q       <= rr2_d;
            rr3_q       <= rr3_d;
            out_valid_q <= out_valid_d;
            pipe_q      <= pipe_d;
        end
    end

    // the PRNG advances every cycle in both states; reseed restarts warm-up
    always_comb begin
        s_d     = seed_valid ? fix(seed) : xs(s_q);
        cnt_d   = seed_valid ? 2'd0 : (run ? cnt_q : cnt_q + 2'd1);
        state_d = seed_valid ? WARMUP : ((!run && cnt_q == 2'd3) ? RUN : state_q);
    end

    // the top two PRNG bytes mask the operands, the low six feed the gadget
    always_comb begin
        r0_d        = run ? s_q[7:0]   : '0;
        r1_d        = run ? s_q[15:8]  : '0;
        rr0_d       = run ? s_q[23:16] : '0;
        rr1_d       = run ? s_q[31:24] : '0;
        rr2_d       = run ? s_q[39:32] : '0;
        rr3_d       = run ? s_q[47:40] : '0;
        a0_d        = acc ? a ^ s_q[55:48] : '0;
        a1_d        = acc ? s_q[55:48]     : '0;
        b0_d        = acc ? b ^ s_q[63:56] : '0;
        b1_d        = acc ? s_q[63:56]     : '0;
        out_valid_d = acc;
        pipe_d      = '0;
        pipe_d[0]   = out_valid_q;
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    assign a0        = a0_q;
    assign a1        = a1_q;
    assign b0        = b0_q;
    assign b1        = b1_q;
    assign r0        = r0_q;
    assign r1        = r1_q;
    assign r_0       = rr0_q;
    assign r_1       = rr1_q;
    assign r_2       = rr2_q;
    assign r_3       = rr3_q;
    assign out_valid = out_valid_q;
    assign res_valid = pipe_q[LATENCY-1];
endmodule

// File: tb/tb_comar_share_gen.sv
// tb_comar_share_gen: directed self-checking bench for comar_share_gen.
module tb_comar_share_gen;
    localparam logic [63:0] ZERO_SUB = 64'h9E37_79B9_7F4A_7C15;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, seed_valid, out_valid, res_valid;
    logic [7:0]  a, b, a0, a1, b0, b1, r0, r1, r_0, r_1, r_2, r_3;
    logic [63:0] seed;

    int n_run = 0, n_fail = 0, ov_cnt = 0, rv_cnt = 0;

    logic [63:0] ms = '0;
    logic        mrun = 1'b0, mov = 1'b0;
    logic [1:0]  mcnt = '0;
    logic [31:0] mshares = '0;
    logic [47:0] mr = '0;
    logic [2:0]  mpipe = '0;

    comar_share_gen #(.WIDTH(8), .SEED(64'h1), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .seed_valid(seed_valid), .seed(seed),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .r0(r0), .r1(r1), .r_0(r_0), .r_1(r_1), .r_2(r_2), .r_3(r_3),
        .out_valid(out_valid), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    function automatic logic [63:0] fix(input logic [63:0] v);
        return (v == 64'd0) ? ZERO_SUB : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, check in_ready, step the model, check registered outputs
    task automatic cyc(input logic r, input logic sv, input logic [63:0] sd,
                       input logic iv, input logic [7:0] av, input logic [7:0] bv);
        logic acc;
        rst = r; seed_valid = sv; seed = sd; in_valid = iv; a = av; b = bv;
        #1;
        check("in_ready", 64'(in_ready), 64'(!r && !sv && mrun));
        acc = !r && !sv && mrun && iv;
        @(posedge clk);
        if (r) begin
            ms = fix(64'h1); mrun = 1'b0; mcnt = 2'd0;
            mshares = '0; mr = '0; mov = 1'b0; mpipe = '0;
        end else begin
            mpipe   = {mpipe[1:0], mov};
            mr      = mrun ? ms[47:0] : 48'd0;
            mshares = acc ? {av ^ ms[55:48], ms[55:48], bv ^ ms[63:56], ms[63:56]} : 32'd0;
            mov     = acc;
            if (sv) begin
                ms = fix(sd); mcnt = 2'd0; mrun = 1'b0;
            end else begin
                ms = xs(ms);
                if (!mrun) begin
                    if (mcnt == 2'd3) mrun = 1'b1;
                    mcnt = mcnt + 2'd1;
                end
            end
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(mov));
        check("res_valid", 64'(res_valid), 64'(mpipe[2]));
        check("shares", 64'({a0, a1, b0, b1}), 64'(mshares));
        check("rand", 64'({r_3, r_2, r_1, r_0, r1, r0}), 64'(mr));
        ov_cnt += int'(out_valid);
        rv_cnt += int'(res_valid);
    endtask

    initial begin
        int k;
        cyc(1, 0, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 8'hA5, 8'h3C);
        rst = 1'b0; seed_valid = 1'b0; in_valid = 1'b0;
        #1;
        check("ready_after_warmup", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00, 8'h00);

        cyc(0, 0, 0, 1, 8'hA5, 8'h3C);
        check("ov_accept", 64'(out_valid), 64'd1);
        check("a_unmask", 64'(a0 ^ a1), 64'hA5);
        check("b_unmask", 64'(b0 ^ b1), 64'h3C);
        k = 0;
        while (!res_valid && k < 10) begin
            cyc(0, 0, 0, 0, 8'h00, 8'h00);
            k++;
        end
        check("rv_latency", 64'(k), 64'd3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00, 8'h00);

        cyc(0, 1, 64'd0, 1, 8'h11, 8'h22);
        check("reseed_no_ov", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 8'h11, 8'h22);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00, 8'h00);

        ov_cnt = 0; rv_cnt = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 8'(i * 17), 8'(~i));
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 8'h00, 8'h00);
        check("b2b_ov", 64'(ov_cnt), 64'd10);
        check("b2b_rv", 64'(rv_cnt), 64'd10);

        cyc(0, 0, 0, 1, 8'h5A, 8'hC3);
        ov_cnt = 0; rv_cnt = 0;
        cyc(1, 0, 0, 1, 8'h5A, 8'hC3);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 8'h00, 8'h00);
        check("rst_ov", 64'(ov_cnt), 64'd0);
        check("rst_rv", 64'(rv_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
